// File: rtl/rom_download_packer.sv
// rom_download_packer: packs the HPS ioctl byte stream into little-endian
// 32-bit words and writes them to SDRAM over a req/ack port. A small word
// FIFO absorbs SDRAM latency, and ioctl_wait holds the HPS off as it fills.
module rom_download_packer #(
  parameter logic [22:0] BASE_ADDR  = '0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned   PW     = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   C_FULL = (PW+1)'(FIFO_DEPTH);
  // One slot of headroom: the HPS may send one more byte after ioctl_wait rises.
  localparam logic [PW:0]   C_HIGH = (PW+1)'(FIFO_DEPTH - 1);
  localparam logic [PW:0]   C_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] C_PONE = PW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state, w_state_n;
  logic          r_pend_valid, w_pend_valid_n;
  logic [17:0]   r_pend_word, w_pend_word_n;
  logic [31:0]   r_pend_data, w_pend_data_n;
  logic [22:0]   r_mem_addr [FIFO_DEPTH];
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count, w_count_n;
  logic          r_wait, r_overflow;

  logic          w_wr, w_same, w_full, w_empty, w_pop;
  logic [17:0]   w_word;
  logic [1:0]    w_lane;
  logic [31:0]   w_byte_word, w_lane_mask, w_merged;
  logic          w_push, w_push_ok;
  logic [17:0]   w_push_word;
  logic [31:0]   w_push_data;
  logic [22:0]   w_push_addr;

  assign w_wr        = ioctl_download & ioctl_wr;
  assign w_word      = ioctl_addr[19:2];
  assign w_lane      = ioctl_addr[1:0];
  assign w_byte_word = {24'h0, ioctl_data} << {w_lane, 3'b000};
  assign w_lane_mask = 32'h0000_00FF << {w_lane, 3'b000};
  assign w_merged    = (r_pend_data & ~w_lane_mask) | w_byte_word;
  assign w_same      = r_pend_valid && (r_pend_word == w_word);
  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);
  assign w_pop       = sdram_ack & ~w_empty;
  // A pop on the same edge frees the slot being written, so a full FIFO still accepts.
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_push_addr = BASE_ADDR + {5'h0, w_push_word};

  // Packer: merge bytes into the pending word and decide what gets pushed
  always_comb begin
    w_push         = 1'b0;
    w_push_word    = r_pend_word;
    w_push_data    = r_pend_data;
    w_pend_valid_n = r_pend_valid;
    w_pend_word_n  = r_pend_word;
    w_pend_data_n  = r_pend_data;
    if (w_wr) begin
      if (w_same) begin
        if (w_lane == 2'd3) begin
          w_push         = 1'b1;
          w_push_data    = w_merged;
          w_pend_valid_n = 1'b0;
          w_pend_data_n  = '0;
        end else begin
          w_pend_data_n  = w_merged;
        end
      end else begin
        w_pend_valid_n = 1'b1;
        w_pend_word_n  = w_word;
        w_pend_data_n  = w_byte_word;
        // Only one push per edge: a lane-3 byte that also displaces an older
        // pending word stays pending and goes out with the next push.
        if (r_pend_valid) begin
          w_push = 1'b1;
        end else if (w_lane == 2'd3) begin
          w_push         = 1'b1;
          w_push_word    = w_word;
          w_push_data    = w_byte_word;
          w_pend_valid_n = 1'b0;
          w_pend_data_n  = '0;
        end
      end
    end else if (r_state == S_FLUSH && !ioctl_download && r_pend_valid &&
                 (!w_full || w_pop)) begin
      w_push         = 1'b1;
      w_pend_valid_n = 1'b0;
      w_pend_data_n  = '0;
    end
  end

  // Download sequencing: IDLE -> LOAD -> FLUSH -> DONE, re-entering LOAD if re-asserted
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (ioctl_download) w_state_n = S_LOAD;
      S_LOAD:  if (!ioctl_download) w_state_n = S_FLUSH;
      S_FLUSH: begin
        if (w_empty) begin
          if (ioctl_download)     w_state_n = S_LOAD;
          else if (!r_pend_valid) w_state_n = S_DONE;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // FIFO occupancy after this edge's push and pop
  always_comb begin
    w_count_n = r_count;
    if (w_push_ok && !w_pop)      w_count_n = r_count + C_ONE;
    else if (!w_push_ok && w_pop) w_count_n = r_count - C_ONE;
  end

  // FIFO storage; contents are only visible through a nonzero count
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_addr[r_wptr] <= w_push_addr;
      r_mem_data[r_wptr] <= w_push_data;
    end
  end

  // Packer, FIFO pointers, state and status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_word  <= '0;
      r_pend_data  <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_wait       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pend_valid <= w_pend_valid_n;
      r_pend_word  <= w_pend_word_n;
      r_pend_data  <= w_pend_data_n;
      r_count      <= w_count_n;
      if (w_push_ok) r_wptr <= r_wptr + C_PONE;
      if (w_pop)     r_rptr <= r_rptr + C_PONE;
      r_wait       <= (w_count_n >= C_HIGH);
      if (w_push && !w_push_ok)
        r_overflow <= 1'b1;
      else if (r_state == S_IDLE && ioctl_download)
        r_overflow <= 1'b0;
    end
  end

  assign sdram_req  = ~w_empty;
  assign sdram_we   = sdram_req;
  assign sdram_addr = sdram_req ? r_mem_addr[r_rptr] : '0;
  assign sdram_data = sdram_req ? r_mem_data[r_rptr] : '0;
  assign ioctl_wait = r_wait;
  assign busy       = r_pend_valid | ~w_empty;
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_download_packer.sv
// tb_rom_download_packer: table vectors, directed multi-cycle sequences and
// randomized downloads checked against a word-grouping reference model.
module tb_rom_download_packer;

  localparam logic [22:0] BASE = 23'h7F0000;

  logic        clk = 1'b0;
  logic        reset_n, ioctl_download, ioctl_wr, sdram_ack;
  logic [19:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait, sdram_we, sdram_req, busy, done, overflow;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;

  int tests = 0;
  int fails = 0;
  int ack_mode = 0;   // 0 never, 1 random (even without req), 2 ack every req, 3 manual
  int done_cnt = 0;

  logic [22:0] cap_a[$];
  logic [31:0] cap_d[$];
  logic [22:0] exp_a[$];
  logic [31:0] exp_d[$];

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    logic [22:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  always #5 clk = ~clk;

  rom_download_packer #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .busy(busy), .done(done), .overflow(overflow)
  );

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic logic [63:0] outs();
    return {3'b0, ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req,
            busy, done, overflow};
  endfunction

  // Record every accepted SDRAM write and every done pulse
  always @(negedge clk) begin
    if (reset_n && sdram_req && sdram_ack) begin
      cap_a.push_back(sdram_addr);
      cap_d.push_back(sdram_data);
    end
    if (reset_n && done) done_cnt++;
  end

  task automatic step();
    case (ack_mode)
      0:       sdram_ack = 1'b0;
      1:       sdram_ack = ($urandom_range(0, 2) == 0);
      2:       sdram_ack = sdram_req;
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d, input bit obey);
    if (obey) begin
      for (int t = 0; t < 2000 && ioctl_wait; t++) step();
      if (ioctl_wait) check("wait_timeout", 64'(ioctl_wait), 64'(0));
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic finish_download(input string tag);
    bit seen;
    seen = 1'b0;
    ioctl_download = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      step();
      seen = done;
    end
    check({tag, "_done"}, 64'(seen), 64'(1));
    step();
  endtask

  task automatic expect_word(input logic [17:0] w, input logic [31:0] d);
    exp_a.push_back(BASE + {5'h0, w});
    exp_d.push_back(d);
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, 64'(cap_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(cap_a[i]), 64'(exp_a[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(cap_d[i]), 64'(exp_d[i]));
    end
    cap_a.delete(); cap_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[7];
    int          sent, d0, nruns, lo, hi;
    logic [17:0] wv, prev_w;
    logic [31:0] wd;
    logic [7:0]  b;

    vt[0] = '{20'h00000, 8'h5A, 23'h7F0000, 32'h0000005A};
    vt[1] = '{20'h00001, 8'hC3, 23'h7F0000, 32'h0000C300};
    vt[2] = '{20'h00102, 8'h7E, 23'h7F0040, 32'h007E0000};
    vt[3] = '{20'h00403, 8'h99, 23'h7F0100, 32'h99000000};
    vt[4] = '{20'hFFFFF, 8'h01, 23'h02FFFF, 32'h01000000};
    vt[5] = '{20'hFFFFC, 8'hFF, 23'h02FFFF, 32'h000000FF};
    vt[6] = '{20'h80002, 8'hE1, 23'h010000, 32'h00E10000};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; sdram_ack = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    step(); step();
    check("reset_outs", outs(), 64'(0));
    reset_n = 1'b1;
    step();
    check("idle_outs", outs(), 64'(0));

    // Single bytes in each lane, including the address wrap at the top
    ack_mode = 2;
    for (int i = 0; i < 7; i++) begin
      ioctl_download = 1'b1;
      step();
      send_byte(vt[i].addr, vt[i].data, 1'b1);
      finish_download($sformatf("vec%0d", i));
      check($sformatf("vec%0d_count", i), 64'(cap_a.size()), 64'(1));
      if (cap_a.size() > 0) begin
        check($sformatf("vec%0d_addr", i), 64'(cap_a[0]), 64'(vt[i].exp_addr));
        check($sformatf("vec%0d_data", i), 64'(cap_d[0]), 64'(vt[i].exp_data));
      end
      cap_a.delete(); cap_d.delete();
    end

    // Sequential word, manual ack three cycles later, done at F+2
    ack_mode = 3; sdram_ack = 1'b0;
    ioctl_download = 1'b1;
    step();
    send_byte(20'h0, 8'h11, 1'b1);
    send_byte(20'h1, 8'h22, 1'b1);
    send_byte(20'h2, 8'h33, 1'b1);
    send_byte(20'h3, 8'h44, 1'b1);
    check("seq_req_n1", 64'(sdram_req), 64'(1));
    check("seq_we_n1", 64'(sdram_we), 64'(1));
    check("seq_addr_n1", 64'(sdram_addr), 64'(BASE));
    check("seq_data_n1", 64'(sdram_data), 64'(32'h44332211));
    step(); step();
    check("seq_req_hold", 64'(sdram_req), 64'(1));
    check("seq_data_hold", 64'(sdram_data), 64'(32'h44332211));
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("seq_req_drop", 64'(sdram_req), 64'(0));
    check("seq_busy_drop", 64'(busy), 64'(0));
    expect_word(18'h0, 32'h44332211);
    ioctl_download = 1'b0;
    step();
    check("seq_done_f1", 64'(done), 64'(0));
    step();
    check("seq_done_f2", 64'(done), 64'(1));
    step();
    check("seq_done_f3", 64'(done), 64'(0));
    compare_words("seq");

    // Partial word flushed when the download ends
    ack_mode = 2;
    ioctl_download = 1'b1;
    step();
    send_byte(20'h104, 8'hAA, 1'b1);
    send_byte(20'h105, 8'hBB, 1'b1);
    check("part_busy", 64'(busy), 64'(1));
    check("part_req", 64'(sdram_req), 64'(0));
    expect_word(18'h41, 32'h0000BBAA);
    finish_download("part");
    compare_words("part");

    // Non-sequential jump pushes the old partial word first
    ack_mode = 0;
    ioctl_download = 1'b1;
    step();
    send_byte(20'h10, 8'h5C, 1'b1);
    send_byte(20'h11, 8'hD2, 1'b1);
    send_byte(20'h80, 8'h3B, 1'b1);
    check("jump_req", 64'(sdram_req), 64'(1));
    check("jump_addr", 64'(sdram_addr), 64'(BASE + 23'h4));
    check("jump_data", 64'(sdram_data), 64'(32'h0000D25C));
    expect_word(18'h4, 32'h0000D25C);
    expect_word(18'h20, 32'h0000003B);
    ack_mode = 2;
    finish_download("jump");
    compare_words("jump");

    // Backpressure: no acks until ioctl_wait rises, then drain
    ack_mode = 0;
    ioctl_download = 1'b1;
    step();
    sent = 0;
    while (sent < 32 && !ioctl_wait) begin
      send_byte(20'(sent), 8'(sent * 7 + 3), 1'b0);
      sent++;
    end
    check("bp_wait", 64'(ioctl_wait), 64'(1));
    check("bp_ovf", 64'(overflow), 64'(0));
    check("bp_head", 64'(sdram_addr), 64'(BASE));
    ack_mode = 1;
    for (int i = sent; i < 32; i++) send_byte(20'(i), 8'(i * 7 + 3), 1'b1);
    for (int w = 0; w < 8; w++)
      expect_word(18'(w), {8'(w*28 + 24), 8'(w*28 + 17), 8'(w*28 + 10), 8'(w*28 + 3)});
    finish_download("bp");
    compare_words("bp");
    check("bp_ovf_end", 64'(overflow), 64'(0));

    // Overflow: five words into a four-deep FIFO with acks held off
    ack_mode = 0;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 20; i++) send_byte(20'h1000 + 20'(i), 8'(i * 5 + 1), 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_wait", 64'(ioctl_wait), 64'(1));
    check("ovf_head", 64'(sdram_addr), 64'(BASE + 23'h400));
    for (int w = 0; w < 4; w++)
      expect_word(18'h400 + 18'(w),
                  {8'(w*20 + 16), 8'(w*20 + 11), 8'(w*20 + 6), 8'(w*20 + 1)});
    ack_mode = 2;
    finish_download("ovf");
    compare_words("ovf");
    check("ovf_sticky", 64'(overflow), 64'(1));
    ioctl_download = 1'b1;
    step();
    check("ovf_clear", 64'(overflow), 64'(0));
    finish_download("ovf_clr");
    compare_words("ovf_clr");

    // Download re-asserted while flushing: back to LOAD, no done pulse
    ack_mode = 0;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send_byte(20'h800 + 20'(i), 8'h60 + 8'(i), 1'b1);
    ioctl_download = 1'b0;
    step(); step();
    d0 = done_cnt;
    ioctl_download = 1'b1;
    ack_mode = 2;
    repeat (4) step();
    check("reflush_nodone", 64'(done_cnt), 64'(d0));
    check("reflush_idle", 64'(busy), 64'(0));
    send_byte(20'h900, 8'hA5, 1'b1);
    send_byte(20'h901, 8'h5A, 1'b1);
    expect_word(18'h200, 32'h63626160);
    expect_word(18'h240, 32'h00005AA5);
    finish_download("reflush");
    compare_words("reflush");

    // Reset while a request is outstanding
    ack_mode = 0;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send_byte(20'h20 + 20'(i), 8'hC0 + 8'(i), 1'b1);
    check("rst_req_before", 64'(sdram_req), 64'(1));
    d0 = done_cnt;
    reset_n = 1'b0;
    step();
    check("rst_outs", outs(), 64'(0));
    reset_n = 1'b1;
    ioctl_download = 1'b0;
    repeat (4) step();
    check("rst_nodone", 64'(done_cnt), 64'(d0));
    check("rst_req_after", 64'(sdram_req), 64'(0));
    check("rst_nowrites", 64'(cap_a.size()), 64'(0));
    cap_a.delete(); cap_d.delete();

    // Randomized downloads against the word-grouping model
    for (int it = 0; it < 8; it++) begin
      ack_mode = 1;
      ioctl_wr = 1'b1; ioctl_addr = 20'($urandom); ioctl_data = 8'($urandom);
      step();
      ioctl_wr = 1'b0;
      ioctl_download = 1'b1;
      step();
      prev_w = '0;
      nruns = $urandom_range(4, 20);
      for (int r = 0; r < nruns; r++) begin
        if (r > 0 && $urandom_range(0, 2) == 0) wv = prev_w + 18'd1;
        else wv = 18'($urandom_range(0, 32'h3FFFF));
        if (r > 0 && wv == prev_w) wv = wv + 18'd1;
        lo = $urandom_range(0, 3);
        hi = $urandom_range(lo, 3);
        wd = '0;
        for (int l = lo; l <= hi; l++) begin
          b  = 8'($urandom);
          wd = wd | (32'(b) << (8 * l));
          send_byte({wv, 2'(l)}, b, 1'b1);
          repeat ($urandom_range(0, 2)) step();
        end
        expect_word(wv, wd);
        prev_w = wv;
      end
      finish_download($sformatf("rnd%0d", it));
      compare_words($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_ovf", it), 64'(overflow), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
